seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Reverse of our hex-to-7-segment encoder. Watches a multiplexed, active-low
//  7-segment display bus (segments + digit strobes) and recovers the hex
//  nibble shown on each digit. Delivers complete frames over a valid/ready
//  handshake. Used to sniff or self-check display drivers on the TinyFPGA.
// PARAMETERS
//  DIGITS         4  number of multiplexed digits (1..8)
//  STABLE_CYCLES  4  cycles a sampled {dig,seg} must hold before acceptance (>=2)
// PORTS
//  CLK          in   1          system clock
//  RST          in   1          synchronous, active-high reset
//  seg_n        in   7          segments, active low, ordered {G,F,E,D,C,B,A}; asynchronous
//  dig_n        in   DIGITS     digit strobes, active low; asynchronous
//  frame_valid  out  1          frame_value/frame_err hold a complete frame
//  frame_ready  in   1          consumer accepts the frame when frame_valid && frame_ready
//  frame_value  out  4*DIGITS   nibble per digit; digit i in [4i+3:4i]
//  frame_err    out  DIGITS     1 = digit i showed an illegal pattern (nibble forced to 0)
//  overrun      out  1          sticky; a completed frame was dropped
// BEHAVIOUR
//  - Reset: all outputs 0; sync flops, stability counter, slots and seen mask cleared.
//  - seg_n and dig_n pass through a 2-flop synchronizer. Decoding works on
//    seg = ~seg_n and dig = ~dig_n.
//  - Stability counter: if the sample differs from the previous sample, cnt = 0.
//    Otherwise cnt saturates at STABLE_CYCLES-1. An accept pulse fires once, on
//    the cycle cnt first reaches STABLE_CYCLES-1. It does not fire again until
//    the sample changes. Latency from a pin change to accept is
//    2 + STABLE_CYCLES cycles.
//  - On accept: if dig is one-hot (bit i), slot i <= decode(seg) and seen[i] <= 1.
//    If dig is zero or multi-hot: no write.
//  - Decode table (seg, G..A -> nibble):
//      3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7,
//      7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
//    Any other pattern gives nibble 0 and err 1.
//  - Frame completion is evaluated on the cycle after seen becomes all-ones:
//    - if !frame_valid || frame_ready: load frame_value/frame_err from the slots,
//      frame_valid <= 1, seen <= 0.
//    - else: overrun <= 1, seen <= 0, frame dropped, output held.
//  - Handshake: while frame_valid && !frame_ready, outputs are stable.
//    frame_valid && frame_ready with no load in that cycle gives frame_valid <= 0.
//    A load in the same cycle as a handshake is back-to-back: frame_valid stays 1.
//  - Slots keep their last value across frames. A digit rewritten before
//    completion takes its newest value.
//  - overrun clears only on RST. RST mid-frame discards partial slots and any
//    pending frame.
// CONFIGURATION
//  BLANK_OK_EN defined: seg == 00 (all segments off) is a legal blank.
//    The slot gets nibble 0, err 0, and seen is set.
//  BLANK_OK_EN undefined: seg == 00 is illegal (nibble 0, err 1).
// STRUCTURE
//  - Package seg_pkg: SEG_W = 7 and the 16-entry SEG_CODE table (nibble ->
//    pattern), shared with the encoder so the two always agree; plus the
//    SEG_BLANK constant.
//  - Sub-module seg_pattern_decode: combinational {seg} -> {nibble, err} lookup
//    against SEG_CODE. Hosts the BLANK_OK_EN switch.
//  - Top: synchronizer, stability counter, slot/seen registers, output and
//    handshake registers.
// TESTING (DIGITS=4, STABLE_CYCLES=4)
//  1. Drive digits 0..3 with seg_n = ~{3F,06,5B,4F}, each held 8 cycles, ready=1
//     -> one frame_valid pulse, frame_value=16'h3210, frame_err=0.
//  2. Hold one digit pattern for only 3 cycles, then change
//     -> no accept, seen unchanged, no frame.
//  3. Digit 2 shows 0x7E -> frame_err=4'b0100 and nibble 2 = 0.
//     Separately, dig_n=4'b1100 (two active) -> no slot written.
//  4. ready=0 while frame 1 is held, then a second full scan completes
//     -> overrun=1, frame 1 outputs unchanged. After ready=1, frame_valid drops.
//  5. seg=00 on digit 1: with BLANK_OK_EN -> err bit 1 = 0;
//     without BLANK_OK_EN -> err bit 1 = 1.
//  6. Assert RST after 2 of 4 digits are captured, then scan all 4
//     -> exactly one frame with only the post-reset values; overrun=0.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared 7-segment code table for the segment encoder and decoder
//
// Contents:
//   SEG_W      segment bus width, ordered {G,F,E,D,C,B,A}
//   SEG_BLANK  all segments off
//   SEG_CODE   nibble -> active-high segment pattern, entry i shows hex digit i
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Leftmost element is index 15 (F), rightmost is index 0 (0).
    localparam logic [15:0][SEG_W-1:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational segment pattern to hex nibble lookup
//
// Ports:
//   seg     in   SEG_W  active-high segment pattern {G,F,E,D,C,B,A}
//   nibble  out  4      decoded hex value, 0 when the pattern is not recognised
//   err     out  1      pattern is not a legal digit
//
// Build option: define BLANK_OK_EN to treat an all-off pattern as a legal
// blank (nibble 0, err 0). Without it a blank digit is reported as an error.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       nibble,
    output logic             err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                nibble = i[3:0];
                err    = 1'b0;
            end
        end
`ifdef BLANK_OK_EN
        if (seg == SEG_BLANK) begin
            err = 1'b0;
        end
`else
        // A dark digit carries no information, so it counts as illegal.
        if (seg == SEG_BLANK) begin
            err = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers hex frames from a multiplexed active-low 7-segment bus
//
// Parameters:
//   DIGITS         number of multiplexed digits (1..8)
//   STABLE_CYCLES  cycles a synchronised {dig,seg} sample must hold to be accepted (>=2)
//
// Ports:
//   CLK          in   1          system clock
//   RST          in   1          synchronous active-high reset
//   seg_n        in   7          segments, active low, {G,F,E,D,C,B,A}; asynchronous
//   dig_n        in   DIGITS     digit strobes, active low; asynchronous
//   frame_valid  out  1          frame_value/frame_err hold a complete frame
//   frame_ready  in   1          frame consumed when frame_valid && frame_ready
//   frame_value  out  4*DIGITS   nibble per digit, digit i in [4i+3:4i]
//   frame_err    out  DIGITS     digit i showed an illegal pattern (nibble forced to 0)
//   overrun      out  1          sticky: a completed frame was dropped
//
// Build option: BLANK_OK_EN (see seg_pattern_decode) makes a blank digit legal.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [SEG_W-1:0]      seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [4*DIGITS-1:0]   frame_value,
    output logic [DIGITS-1:0]     frame_err,
    output logic                  overrun
);

    localparam int SW = DIGITS + SEG_W;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0]       sync1, sync2, prev;
    logic [CW-1:0]       cnt;
    logic [SEG_W-1:0]    seg;
    logic [DIGITS-1:0]   dig;
    logic                same, accept, wr_ok, complete;
    logic [3:0]          dec_nib;
    logic                dec_err;
    logic [4*DIGITS-1:0] slot_val;
    logic [DIGITS-1:0]   slot_err, seen, seen_next;

    assign {dig, seg} = ~sync2;
    assign same       = (sync2 == prev);
    // Fires on the edge where cnt steps to CNT_MAX; saturation keeps it single-shot.
    assign accept     = same && (cnt == CNT_ARM);
    assign wr_ok      = accept && $onehot(dig);
    assign complete   = &seen;

    seg_pattern_decode u_dec (
        .seg    (seg),
        .nibble (dec_nib),
        .err    (dec_err)
    );

    // A completing frame clears seen; a digit accepted in that same cycle
    // already belongs to the next frame.
    always_comb begin
        seen_next = complete ? '0 : seen;
        if (wr_ok) begin
            seen_next = seen_next | dig;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= {dig_n, seg_n};
            sync2 <= sync1;
            prev  <= sync2;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_val <= '0;
            slot_err <= '0;
            seen     <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_ok && dig[i]) begin
                    slot_val[4*i +: 4] <= dec_nib;
                    slot_err[i]        <= dec_err;
                end
            end
            seen <= seen_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_valid <= 1'b0;
            frame_value <= '0;
            frame_err   <= '0;
            overrun     <= 1'b0;
        end else if (complete) begin
            if (!frame_valid || frame_ready) begin
                frame_valid <= 1'b1;
                frame_value <= slot_val;
                frame_err   <= slot_err;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_n = 4'hF;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic [15:0] frame_value;
    logic [3:0]  frame_err;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    int          hs_cnt = 0;
    logic [15:0] hs_val = '0;
    logic [3:0]  hs_err = '0;

    seg_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_value (frame_value),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (frame_valid && frame_ready) begin
            hs_cnt <= hs_cnt + 1;
            hs_val <= frame_value;
            hs_err <= frame_err;
        end
    end

    task automatic show(input int d, input logic [6:0] pat, input int n);
        logic [3:0] one;
        one   = 4'b0001;
        dig_n = ~(one << d);
        seg_n = ~pat;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        dig_n = 4'hF;
        seg_n = 7'h7F;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        show(0, p0, 8);
        show(1, p1, 8);
        show(2, p2, 8);
        show(3, p3, 8);
        idle(6);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        total++; if (frame_value !== 16'h0) begin bad++; $display("FAIL reset_value got %h want 0000", frame_value); end
        total++; if (frame_err !== 4'h0) begin bad++; $display("FAIL reset_err got %b want 0000", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got %b want 0", overrun); end
    endtask

    task automatic test_basic_frame();
        int base;
        idle(8);
        base = hs_cnt;
        scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL basic_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'h3210) begin bad++; $display("FAIL basic_value got %h want 3210", hs_val); end
        total++; if (hs_err !== 4'h0) begin bad++; $display("FAIL basic_err got %b want 0000", hs_err); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got %b want 0", frame_valid); end
    endtask

    task automatic test_short_hold();
        int base;
        base = hs_cnt;
        show(0, 7'h06, 3);
        idle(8);
        show(1, 7'h66, 8);
        show(2, 7'h6D, 8);
        show(3, 7'h7D, 8);
        idle(6);
        total++; if (hs_cnt - base !== 0) begin bad++; $display("FAIL short_no_frame got %0d want 0", hs_cnt - base); end
        show(0, 7'h7F, 8);
        idle(6);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL short_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'h6548) begin bad++; $display("FAIL short_value got %h want 6548", hs_val); end
    endtask

    task automatic test_illegal_and_multihot();
        int base;
        base = hs_cnt;
        scan(7'h3F, 7'h06, 7'h7E, 7'h4F);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL illegal_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'h3010) begin bad++; $display("FAIL illegal_value got %h want 3010", hs_val); end
        total++; if (hs_err !== 4'b0100) begin bad++; $display("FAIL illegal_err got %b want 0100", hs_err); end
        base = hs_cnt;
        dig_n = 4'b1100;
        seg_n = ~7'h77;
        repeat (8) @(posedge CLK);
        #1;
        show(2, 7'h39, 8);
        show(3, 7'h5E, 8);
        idle(6);
        total++; if (hs_cnt - base !== 0) begin bad++; $display("FAIL multihot_no_frame got %0d want 0", hs_cnt - base); end
        show(0, 7'h71, 8);
        show(1, 7'h79, 8);
        idle(6);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL multihot_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'hDCEF) begin bad++; $display("FAIL multihot_value got %h want dcef", hs_val); end
    endtask

    task automatic test_overrun();
        int base;
        base = hs_cnt;
        frame_ready = 1'b0;
        scan(7'h3F, 7'h06, 7'h5B, 7'h4F);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got %b want 1", frame_valid); end
        total++; if (frame_value !== 16'h3210) begin bad++; $display("FAIL hold_value got %h want 3210", frame_value); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL hold_overrun got %b want 0", overrun); end
        scan(7'h66, 7'h6D, 7'h7D, 7'h07);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got %b want 1", overrun); end
        total++; if (frame_value !== 16'h3210) begin bad++; $display("FAIL overrun_value got %h want 3210", frame_value); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got %b want 1", frame_valid); end
        frame_ready = 1'b1;
        @(posedge CLK);
        #1;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL release_valid got %b want 0", frame_valid); end
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL release_count got %0d want 1", hs_cnt - base); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    endtask

    task automatic test_blank();
        int base;
        logic [3:0] exp_err;
`ifdef BLANK_OK_EN
        exp_err = 4'b0000;
`else
        exp_err = 4'b0010;
`endif
        base = hs_cnt;
        scan(7'h3F, 7'h00, 7'h5B, 7'h4F);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL blank_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'h3200) begin bad++; $display("FAIL blank_value got %h want 3200", hs_val); end
        total++; if (hs_err !== exp_err) begin bad++; $display("FAIL blank_err got %b want %b", hs_err, exp_err); end
    endtask

    task automatic test_reset_midframe();
        int base;
        show(0, 7'h06, 8);
        show(1, 7'h06, 8);
        do_reset();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun got %b want 0", overrun); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got %b want 0", frame_valid); end
        idle(8);
        base = hs_cnt;
        show(2, 7'h77, 8);
        show(3, 7'h7C, 8);
        idle(6);
        total++; if (hs_cnt - base !== 0) begin bad++; $display("FAIL midreset_partial got %0d want 0", hs_cnt - base); end
        show(0, 7'h7F, 8);
        show(1, 7'h67, 8);
        idle(6);
        total++; if (hs_cnt - base !== 1) begin bad++; $display("FAIL midreset_count got %0d want 1", hs_cnt - base); end
        total++; if (hs_val !== 16'hBA98) begin bad++; $display("FAIL midreset_value got %h want ba98", hs_val); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midreset_overrun_end got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_short_hold();
        test_illegal_and_multihot();
        test_overrun();
        test_blank();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
